// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch sequencer.
// Optional feature macro used by the slice: FETCH_PERF_CNT_EN.
package fetch_pkg;

  // Fetch FSM encoding, also exported on the fsm_state port.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    HALT  = 2'd3
  } fetch_state_t;

  // Default ROM address width and post-redirect bubble count (legal 1..7).
  localparam int PC_W_DEF      = 10;
  localparam int FLUSH_CYC_DEF = 2;

  // Flush down-counter width; wide enough for the largest bubble count of 7.
  localparam int FLUSH_CNT_W   = 3;

  // Width of each performance counter.
  localparam int PERF_CNT_W    = 16;

endpackage : fetch_pkg

// File: rtl/fetch_perf_cnt.sv
// fetch_perf_cnt: one saturating performance counter. Used only when the
// FETCH_PERF_CNT_EN macro is defined.
module fetch_perf_cnt
  import fetch_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inc,
  output logic [PERF_CNT_W-1:0] count
);

  localparam logic [PERF_CNT_W-1:0] CNT_MAX = {PERF_CNT_W{1'b1}};
  localparam logic [PERF_CNT_W-1:0] CNT_ONE = PERF_CNT_W'(1);
  localparam logic [PERF_CNT_W-1:0] CNT_ZERO = PERF_CNT_W'(0);

  logic [PERF_CNT_W-1:0] count_d;
  logic [PERF_CNT_W-1:0] count_q;

  // Next count: increment on request but stick at all-ones.
  always_comb begin
    count_d = count_q;
    if (inc && (count_q != CNT_MAX)) begin
      count_d = count_q + CNT_ONE;
    end else begin
      count_d = count_q;
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= CNT_ZERO;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule : fetch_perf_cnt

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the instruction-fetch PC, chooses next PC from
// increment / in-bundle jump / execute redirect, and sequences start, halt,
// decode stall and post-redirect flush bubbles.
// Optional feature: define FETCH_PERF_CNT_EN to add fetch_cnt / bubble_cnt.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int PC_W      = PC_W_DEF,
  parameter int FLUSH_CYC = FLUSH_CYC_DEF
)
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stall,
  input  logic                  redir_valid,
  input  logic [PC_W-1:0]       redir_pc,
  input  logic                  jump_hit,
  input  logic [PC_W-1:0]       jump_pc,
  input  logic                  halt_hit,
  output logic [PC_W-1:0]       pc,
  output logic                  bundle_valid,
  output logic [1:0]            fsm_state
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [PERF_CNT_W-1:0] fetch_cnt,
  output logic [PERF_CNT_W-1:0] bubble_cnt
`endif
);

  localparam logic [PC_W-1:0]        PC_ONE     = PC_W'(1);
  localparam logic [PC_W-1:0]        PC_ZERO    = PC_W'(0);
  localparam logic [FLUSH_CNT_W-1:0] FLUSH_LOAD = FLUSH_CNT_W'(FLUSH_CYC);
  localparam logic [FLUSH_CNT_W-1:0] CNT_ONE    = FLUSH_CNT_W'(1);
  localparam logic [FLUSH_CNT_W-1:0] CNT_ZERO   = FLUSH_CNT_W'(0);

  fetch_state_t           state_d, state_q;
  logic [PC_W-1:0]        pc_d, pc_q;
  logic [FLUSH_CNT_W-1:0] flush_cnt_d, flush_cnt_q;
  logic                   bundle_valid_d, bundle_valid_q;

  // Next-state / next-PC selection. Hits are only honoured in RUN, where the
  // fetched bundle is live; redirect always has top priority.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    flush_cnt_d = flush_cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (redir_valid) begin
          pc_d        = redir_pc;
          flush_cnt_d = FLUSH_LOAD;
          state_d     = FLUSH;
        end else if (stall) begin
          pc_d    = pc_q;
          state_d = RUN;
        end else if (halt_hit) begin
          pc_d    = pc_q;
          state_d = HALT;
        end else if (jump_hit) begin
          pc_d = jump_pc;
        end else begin
          pc_d = pc_q + PC_ONE;
        end
      end
      FLUSH: begin
        if (redir_valid) begin
          pc_d        = redir_pc;
          flush_cnt_d = FLUSH_LOAD;
          state_d     = FLUSH;
        end else if (flush_cnt_q == CNT_ONE) begin
          flush_cnt_d = CNT_ZERO;
          state_d     = RUN;
        end else begin
          flush_cnt_d = flush_cnt_q - CNT_ONE;
          state_d     = FLUSH;
        end
      end
      HALT: begin
        if (redir_valid) begin
          pc_d        = redir_pc;
          flush_cnt_d = FLUSH_LOAD;
          state_d     = FLUSH;
        end else if (start) begin
          pc_d    = pc_q + PC_ONE;
          state_d = RUN;
        end else begin
          state_d = HALT;
        end
      end
      default: begin
        state_d     = IDLE;
        pc_d        = PC_ZERO;
        flush_cnt_d = CNT_ZERO;
      end
    endcase
    bundle_valid_d = (state_d == RUN);
  end

  // Sequencer state, PC, flush counter and registered bundle_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      pc_q           <= PC_ZERO;
      flush_cnt_q    <= CNT_ZERO;
      bundle_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      flush_cnt_q    <= flush_cnt_d;
      bundle_valid_q <= bundle_valid_d;
    end
  end

  assign pc           = pc_q;
  assign bundle_valid = bundle_valid_q;
  assign fsm_state    = state_q;

`ifdef FETCH_PERF_CNT_EN
  logic fetch_inc_s;
  logic bubble_inc_s;

  // A RUN cycle without stall delivers a bundle; FLUSH or stalled RUN is a bubble.
  always_comb begin
    fetch_inc_s  = 1'b0;
    bubble_inc_s = 1'b0;
    if (state_q == RUN) begin
      fetch_inc_s  = ~stall;
      bubble_inc_s = stall;
    end else if (state_q == FLUSH) begin
      bubble_inc_s = 1'b1;
    end else begin
      fetch_inc_s  = 1'b0;
      bubble_inc_s = 1'b0;
    end
  end

  fetch_perf_cnt u_fetch_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (fetch_inc_s),
    .count (fetch_cnt)
  );

  fetch_perf_cnt u_bubble_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (bubble_inc_s),
    .count (bubble_cnt)
  );
`endif

endmodule : fetch_sequencer

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed scoreboard bench for fetch_sequencer
// (PC_W=10, FLUSH_CYC=2). Perf-counter steps build only with FETCH_PERF_CNT_EN.
module tb_fetch_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       stall;
  logic       redir_valid;
  logic [9:0] redir_pc;
  logic       jump_hit;
  logic [9:0] jump_pc;
  logic       halt_hit;
  logic [9:0] pc;
  logic       bundle_valid;
  logic [1:0] fsm_state;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] fetch_cnt;
  logic [15:0] bubble_cnt;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [9:0] pc;
    logic       bv;
    logic [1:0] st;
  } exp_t;

  exp_t exp_q[$];

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FL   = 2'd2;
  localparam logic [1:0] S_HALT = 2'd3;

  fetch_sequencer #(.PC_W(10), .FLUSH_CYC(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .stall        (stall),
    .redir_valid  (redir_valid),
    .redir_pc     (redir_pc),
    .jump_hit     (jump_hit),
    .jump_pc      (jump_pc),
    .halt_hit     (halt_hit),
    .pc           (pc),
    .bundle_valid (bundle_valid),
    .fsm_state    (fsm_state)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_cnt    (fetch_cnt),
    .bubble_cnt   (bubble_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, got, want);
    end
  endtask

  // Drive one cycle of inputs, queue the expected post-edge outputs,
  // then pop and compare once the DUT has updated.
  task automatic step(input logic i_start, input logic i_stall,
                      input logic i_redir, input logic [9:0] i_rpc,
                      input logic i_jump, input logic [9:0] i_jpc,
                      input logic i_halt,
                      input logic [9:0] e_pc, input logic e_bv,
                      input logic [1:0] e_st, input string tag);
    exp_t e;
    start       = i_start;
    stall       = i_stall;
    redir_valid = i_redir;
    redir_pc    = i_rpc;
    jump_hit    = i_jump;
    jump_pc     = i_jpc;
    halt_hit    = i_halt;
    exp_q.push_back('{pc: e_pc, bv: e_bv, st: e_st});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk({tag, "_pc"}, 32'(pc), 32'(e.pc));
    chk({tag, "_bv"}, 32'(bundle_valid), 32'(e.bv));
    chk({tag, "_st"}, 32'(fsm_state), 32'(e.st));
  endtask

  initial begin
    rst = 1'b1;
    step(1'b1, 1'b0, 1'b1, 10'd9, 1'b1, 10'd9, 1'b0, 10'd0, 1'b0, S_IDLE, "reset1");
    step(1'b0, 1'b0, 1'b0, 10'd0, 1'b0, 10'd0, 1'b0, 10'd0, 1'b0, S_IDLE, "reset2");
    rst = 1'b0;
    //   start stall redir rpc    jump  jpc      halt  exp_pc   bv    st
    step(1'b0, 1'b0, 1'b0, 10'd0, 1'b0, 10'd0,   1'b0, 10'd0,   1'b0, S_IDLE, "idle_hold");
    step(1'b1, 1'b0, 1'b0, 10'd0, 1'b0, 10'd0,   1'b0, 10'd0,   1'b1, S_RUN,  "start");
    step(1'b0, 1'b0, 1'b0, 10'd0, 1'b0, 10'd0,   1'b0, 10'd1,   1'b1, S_RUN,  "seq1");
    step(1'b1, 1'b0, 1'b0, 10'd0, 1'b0, 10'd0,   1'b0, 10'd2,   1'b1, S_RUN,  "start_in_run");
    step(1'b0, 1'b0, 1'b0, 10'd0, 1'b0, 10'd0,   1'b0, 10'd3,   1'b1, S_RUN,  "seq3");
    step(1'b0, 1'b0, 1'b0, 10'd0, 1'b0, 10'd0,   1'b0, 10'd4,   1'b1, S_RUN,  "seq4");
    step(1'b0, 1'b0, 1'b0, 10'd0, 1'b0, 10'd0,   1'b0, 10'd5,   1'b1, S_RUN,  "seq5");
    step(1'b0, 1'b0, 1'b0, 10'd0, 1'b1, 10'd40,  1'b0, 10'd40,  1'b1, S_RUN,  "jump40");
    step(1'b0, 1'b0, 1'b0, 10'd0, 1'b1, 10'd1023,1'b0, 10'd1023,1'b1, S_RUN,  "jump1023");
    step(1'b0, 1'b0, 1'b0, 10'd0, 1'b0, 10'd0,   1'b0, 10'd0,   1'b1, S_RUN,  "wrap");
    step(1'b0, 1'b0, 1'b0, 10'd0, 1'b1, 10'd7,   1'b0, 10'd7,   1'b1, S_RUN,  "jump7");
    step(1'b0, 1'b0, 1'b1, 10'd100,1'b0,10'd0,   1'b0, 10'd100, 1'b0, S_FL,   "redir100");
    step(1'b0, 1'b0, 1'b0, 10'd0, 1'b0, 10'd0,   1'b0, 10'd100, 1'b0, S_FL,   "flush_b2");
    step(1'b0, 1'b0, 1'b0, 10'd0, 1'b0, 10'd0,   1'b0, 10'd100, 1'b1, S_RUN,  "flush_done");
    step(1'b0, 1'b0, 1'b0, 10'd0, 1'b0, 10'd0,   1'b0, 10'd101, 1'b1, S_RUN,  "after_flush");
    step(1'b0, 1'b0, 1'b1, 10'd100,1'b0,10'd0,   1'b0, 10'd100, 1'b0, S_FL,   "redir_again");
    step(1'b1, 1'b0, 1'b1, 10'd200,1'b0,10'd0,   1'b0, 10'd200, 1'b0, S_FL,   "redir_in_flush");
    step(1'b1, 1'b1, 1'b0, 10'd0, 1'b1, 10'd5,   1'b1, 10'd200, 1'b0, S_FL,   "flush_ignore");
    step(1'b0, 1'b0, 1'b0, 10'd0, 1'b0, 10'd0,   1'b0, 10'd200, 1'b1, S_RUN,  "reflush_done");
    step(1'b0, 1'b0, 1'b0, 10'd0, 1'b1, 10'd12,  1'b0, 10'd12,  1'b1, S_RUN,  "jump12");
    step(1'b0, 1'b1, 1'b0, 10'd0, 1'b0, 10'd0,   1'b0, 10'd12,  1'b1, S_RUN,  "stall1");
    step(1'b0, 1'b1, 1'b0, 10'd0, 1'b1, 10'd77,  1'b0, 10'd12,  1'b1, S_RUN,  "stall2");
    step(1'b0, 1'b1, 1'b0, 10'd0, 1'b0, 10'd0,   1'b0, 10'd12,  1'b1, S_RUN,  "stall3");
    step(1'b0, 1'b0, 1'b0, 10'd0, 1'b0, 10'd0,   1'b0, 10'd13,  1'b1, S_RUN,  "unstall");
    step(1'b0, 1'b1, 1'b1, 10'd300,1'b0,10'd0,   1'b0, 10'd300, 1'b0, S_FL,   "redir_over_stall");
    step(1'b0, 1'b0, 1'b0, 10'd0, 1'b0, 10'd0,   1'b0, 10'd300, 1'b0, S_FL,   "flush3_b2");
    step(1'b0, 1'b0, 1'b0, 10'd0, 1'b0, 10'd0,   1'b0, 10'd300, 1'b1, S_RUN,  "flush3_done");
    step(1'b0, 1'b0, 1'b0, 10'd0, 1'b1, 10'd30,  1'b0, 10'd30,  1'b1, S_RUN,  "jump30");
    step(1'b0, 1'b0, 1'b0, 10'd0, 1'b1, 10'd50,  1'b1, 10'd30,  1'b0, S_HALT, "halt_over_jump");
    step(1'b0, 1'b0, 1'b0, 10'd0, 1'b0, 10'd0,   1'b0, 10'd30,  1'b0, S_HALT, "halt_hold");
    step(1'b0, 1'b0, 1'b0, 10'd0, 1'b1, 10'd60,  1'b1, 10'd30,  1'b0, S_HALT, "halt_ignore_hits");
    step(1'b1, 1'b0, 1'b0, 10'd0, 1'b0, 10'd0,   1'b0, 10'd31,  1'b1, S_RUN,  "halt_start");
    step(1'b0, 1'b0, 1'b0, 10'd0, 1'b0, 10'd0,   1'b1, 10'd31,  1'b0, S_HALT, "halt2");
    step(1'b1, 1'b0, 1'b1, 10'd400,1'b0,10'd0,   1'b0, 10'd400, 1'b0, S_FL,   "halt_redir");
    rst = 1'b1;
    step(1'b1, 1'b0, 1'b1, 10'd500,1'b0,10'd0,   1'b0, 10'd0,   1'b0, S_IDLE, "rst_in_flush");
    rst = 1'b0;
    step(1'b0, 1'b0, 1'b0, 10'd0, 1'b0, 10'd0,   1'b0, 10'd0,   1'b0, S_IDLE, "post_rst");
    step(1'b1, 1'b0, 1'b0, 10'd0, 1'b0, 10'd0,   1'b0, 10'd0,   1'b1, S_RUN,  "restart");
    step(1'b0, 1'b1, 1'b0, 10'd0, 1'b0, 10'd0,   1'b1, 10'd0,   1'b1, S_RUN,  "stall_over_halt");
    step(1'b0, 1'b0, 1'b0, 10'd0, 1'b0, 10'd0,   1'b1, 10'd0,   1'b0, S_HALT, "halt_at_0");

`ifdef FETCH_PERF_CNT_EN
    rst = 1'b1;
    step(1'b0, 1'b0, 1'b0, 10'd0, 1'b0, 10'd0,   1'b0, 10'd0,   1'b0, S_IDLE, "perf_rst");
    rst = 1'b0;
    chk("perf_fetch_rst", 32'(fetch_cnt), 32'd0);
    chk("perf_bubble_rst", 32'(bubble_cnt), 32'd0);
    step(1'b1, 1'b0, 1'b0, 10'd0, 1'b0, 10'd0,   1'b0, 10'd0,   1'b1, S_RUN,  "perf_start");
    for (int i = 1; i <= 9; i++) begin
      step(1'b0, 1'b0, 1'b0, 10'd0, 1'b0, 10'd0, 1'b0, 10'(i), 1'b1, S_RUN, "perf_run");
    end
    step(1'b0, 1'b1, 1'b0, 10'd0, 1'b0, 10'd0,   1'b0, 10'd9,   1'b1, S_RUN,  "perf_stall1");
    step(1'b0, 1'b1, 1'b0, 10'd0, 1'b0, 10'd0,   1'b0, 10'd9,   1'b1, S_RUN,  "perf_stall2");
    step(1'b0, 1'b0, 1'b1, 10'd600,1'b0,10'd0,   1'b0, 10'd600, 1'b0, S_FL,   "perf_redir");
    step(1'b0, 1'b0, 1'b0, 10'd0, 1'b0, 10'd0,   1'b0, 10'd600, 1'b0, S_FL,   "perf_flush_b2");
    step(1'b0, 1'b0, 1'b0, 10'd0, 1'b0, 10'd0,   1'b0, 10'd600, 1'b1, S_RUN,  "perf_flush_done");
    chk("perf_fetch_cnt", 32'(fetch_cnt), 32'd10);
    chk("perf_bubble_cnt", 32'(bubble_cnt), 32'd4);
    start = 1'b0; stall = 1'b0; redir_valid = 1'b0; jump_hit = 1'b0; halt_hit = 1'b0;
    repeat (70000) @(posedge clk);
    #1;
    chk("perf_fetch_sat", 32'(fetch_cnt), 32'h0000FFFF);
    chk("perf_bubble_hold", 32'(bubble_cnt), 32'd4);
`endif

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_fetch_sequencer
